// File: rtl/mac_sequencer.sv
// Operand sequencer for a registered MAC: kernelSize (a,b) beats plus bias fold into one result; MAC_SEQ_RELU_EN clamps negative results to 0.
// Latency: first beat the cycle after start, out_valid 2 cycles after the last beat (start-to-result >= kernelSize+2).
// Backpressure: in_ready only in ACCUM with stalls of any length; the result is held on out_data until out_valid&&out_ready.
module mac_sequencer #(
    parameter int dataWidth  = 16,
    parameter int kernelSize = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [dataWidth-1:0] bias_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [dataWidth-1:0] in_a,
    input  logic [dataWidth-1:0] in_b,
    output logic [dataWidth-1:0] mac_a,
    output logic [dataWidth-1:0] mac_b,
    output logic [dataWidth-1:0] mac_tmp,
    input  logic [dataWidth-1:0] mac_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [dataWidth-1:0] out_data,
    output logic                 busy
);

    localparam int CW = (kernelSize > 1) ? $clog2(kernelSize) : 1;
    localparam logic [CW-1:0] LAST = CW'(kernelSize - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t               state_q;
    logic [CW-1:0]        count_q;
    logic [dataWidth-1:0] bias_q;
    logic [dataWidth-1:0] out_data_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic [dataWidth-1:0] result_d;
    logic                 beat;

    assign beat      = in_valid && in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;

`ifdef MAC_SEQ_RELU_EN
    assign result_d = mac_out[dataWidth-1] ? '0 : mac_out;
`else
    assign result_d = mac_out;
`endif

    // The MAC updates every cycle, so idle ACCUM/DRAIN cycles feed mac_out back with a zero product.
    always_comb begin
        mac_a   = '0;
        mac_b   = '0;
        mac_tmp = '0;
        case (state_q)
            ACCUM: begin
                mac_tmp = mac_out;
                if (beat) begin
                    mac_a   = in_a;
                    mac_b   = in_b;
                    mac_tmp = (count_q == '0) ? bias_q : mac_out;
                end
            end
            DRAIN:   mac_tmp = mac_out;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            bias_q      <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bias_q     <= bias_in;
                        count_q    <= '0;
                        state_q    <= ACCUM;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        count_q <= count_q + CW'(1);
                        if (count_q == LAST) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    out_data_q  <= result_d;
                    state_q     <= OUT;
                    out_valid_q <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: kernelSize=3 and kernelSize=1 instances, each driving a behavioural MAC, checked by a result scoreboard.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_v     [2];
    logic [15:0] bias_v      [2];
    logic        in_valid_v  [2];
    logic        in_ready_v  [2];
    logic [15:0] in_a_v      [2];
    logic [15:0] in_b_v      [2];
    logic [15:0] mac_a_v     [2];
    logic [15:0] mac_b_v     [2];
    logic [15:0] mac_tmp_v   [2];
    logic [15:0] mac_out_v   [2] = '{16'h0, 16'h0};
    logic        out_valid_v [2];
    logic        out_ready_v [2];
    logic [15:0] out_data_v  [2];
    logic        busy_v      [2];

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int          cyc     = 0;
    bit          rnd_rdy = 1'b0;
    bit          prev_ov  [2] = '{1'b0, 1'b0};
    bit          chk_drop [2] = '{1'b0, 1'b0};
    logic [15:0] op_a [8];
    logic [15:0] op_b [8];

    typedef struct {
        int          dut;
        logic [15:0] data;
        int          beat;
    } exp_t;
    exp_t exp_q [$];

    mac_sequencer #(.dataWidth(16), .kernelSize(3)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .bias_in(bias_v[0]),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_a(in_a_v[0]), .in_b(in_b_v[0]),
        .mac_a(mac_a_v[0]), .mac_b(mac_b_v[0]), .mac_tmp(mac_tmp_v[0]), .mac_out(mac_out_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_data(out_data_v[0]), .busy(busy_v[0])
    );

    mac_sequencer #(.dataWidth(16), .kernelSize(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .bias_in(bias_v[1]),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_a(in_a_v[1]), .in_b(in_b_v[1]),
        .mac_a(mac_a_v[1]), .mac_b(mac_b_v[1]), .mac_tmp(mac_tmp_v[1]), .mac_out(mac_out_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_data(out_data_v[1]), .busy(busy_v[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural registered MAC: data_out <= a*b + tmp, truncated to 16 bits.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            mac_out_v[d] <= mac_a_v[d] * mac_b_v[d] + mac_tmp_v[d];
    end

    always @(posedge clk) begin
        #1;
        if (rnd_rdy) begin
            for (int d = 0; d < 2; d++) out_ready_v[d] = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [15:0] finish_val(input longint acc);
        logic [15:0] r;
        r = 16'(acc);
`ifdef MAC_SEQ_RELU_EN
        if (r[15]) r = 16'h0;
`endif
        return r;
    endfunction

    // Scoreboard monitor: latency on the out_valid rise, data on each handshake, one-cycle drop after it.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                if (chk_drop[d]) begin
                    chk_drop[d] = 1'b0;
                    check($sformatf("out_valid_drop%0d", d), 32'(out_valid_v[d]), 32'd0);
                end
                if (out_valid_v[d] && !prev_ov[d]) begin
                    if (exp_q.size() == 0) fail_now($sformatf("unexpected_out_valid%0d", d));
                    else check($sformatf("latency%0d", d), 32'(cyc), 32'(exp_q[0].beat + 2));
                end
                if (out_valid_v[d] && out_ready_v[d]) begin
                    if (exp_q.size() == 0) fail_now($sformatf("unexpected_result%0d", d));
                    else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check($sformatf("result_dut%0d", d), 32'(d), 32'(e.dut));
                        check($sformatf("out_data%0d", d), 32'(out_data_v[d]), 32'(e.data));
                        chk_drop[d] = 1'b1;
                    end
                end
            end
            prev_ov[d] = out_valid_v[d];
        end
    end

    task automatic run(input int d, input logic [15:0] bias, input int n, input bit rnd,
                       input int stall_after, input int abort_after);
        longint acc;
        int     bcyc;
        bit     got;
        acc  = longint'(bias);
        bcyc = 0;
        @(posedge clk); #1;
        start_v[d] = 1'b1;
        bias_v[d]  = bias;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        bias_v[d]  = 16'($urandom);
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                int r;
                r = $urandom_range(0, 3);
                if (r > 0) begin
                    in_valid_v[d] = 1'b0;
                    repeat (r) @(posedge clk);
                    #1;
                end
                start_v[d] = 1'($urandom_range(0, 1));
            end
            in_valid_v[d] = 1'b1;
            in_a_v[d]     = op_a[i];
            in_b_v[d]     = op_b[i];
            got = 1'b0;
            for (int w = 0; w < 200 && !got; w++) begin
                @(negedge clk);
                if (in_ready_v[d]) begin
                    got  = 1'b1;
                    bcyc = cyc;
                end
            end
            if (!got) fail_now($sformatf("in_ready_timeout%0d", d));
            @(posedge clk); #1;
            acc = acc + longint'(op_a[i]) * longint'(op_b[i]);
            if (i == n - 1) start_v[d] = 1'b0;
            if (i == abort_after) begin
                in_valid_v[d] = 1'b0;
                start_v[d]    = 1'b0;
                rst = 1'b0;
                #1;
                check("abort_in_ready", 32'(in_ready_v[d]), 32'd0);
                check("abort_out_valid", 32'(out_valid_v[d]), 32'd0);
                check("abort_busy", 32'(busy_v[d]), 32'd0);
                check("abort_mac_drive", {mac_a_v[d], mac_b_v[d] | mac_tmp_v[d]}, 32'd0);
                @(posedge clk); #1;
                rst = 1'b1;
                return;
            end
            if (i == stall_after) begin
                in_valid_v[d] = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_mac_hold", 32'(mac_out_v[d]), 32'(16'(acc)));
                    @(posedge clk);
                end
                #1;
            end
        end
        in_valid_v[d] = 1'b0;
        exp_q.push_back('{dut: d, data: finish_val(acc), beat: bcyc});
    endtask

    task automatic wait_idle(input int d);
        bit done;
        done = 1'b0;
        for (int w = 0; w < 400 && !done; w++) begin
            @(negedge clk);
            if (!busy_v[d]) done = 1'b1;
        end
        if (!done) fail_now($sformatf("idle_timeout%0d", d));
    endtask

    task automatic set_ops3(input logic [15:0] a0, b0, a1, b1, a2, b2);
        op_a[0] = a0; op_b[0] = b0;
        op_a[1] = a1; op_b[1] = b1;
        op_a[2] = a2; op_b[2] = b2;
    endtask

    initial begin
        bit seen;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; bias_v[d] = 16'h0; in_valid_v[d] = 1'b0;
            in_a_v[d] = 16'h0; in_b_v[d] = 16'h0; out_ready_v[d] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", 32'(in_ready_v[d]), 32'd0);
            check("rst_out_valid", 32'(out_valid_v[d]), 32'd0);
            check("rst_busy", 32'(busy_v[d]), 32'd0);
            check("rst_out_data", 32'(out_data_v[d]), 32'd0);
            check("rst_mac_ab", {mac_a_v[d], mac_b_v[d]}, 32'd0);
            check("rst_mac_tmp", 32'(mac_tmp_v[d]), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;

        set_ops3(16'd2, 16'd3, 16'd4, 16'd1, 16'd1, 16'd1);
        run(0, 16'd5, 3, 1'b0, -1, -1);
        wait_idle(0);
        run(0, 16'd5, 3, 1'b0, 0, -1);
        wait_idle(0);

        // Held result under backpressure, start pulses ignored in OUT and on the handshake.
        out_ready_v[0] = 1'b0;
        run(0, 16'd5, 3, 1'b0, -1, -1);
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            @(negedge clk);
            if (out_valid_v[0]) seen = 1'b1;
        end
        if (!seen) fail_now("out_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("hold_out_valid", 32'(out_valid_v[0]), 32'd1);
            check("hold_out_data", 32'(out_data_v[0]), 32'd16);
            check("hold_in_ready", 32'(in_ready_v[0]), 32'd0);
            @(posedge clk); #1;
            start_v[0] = 1'(i % 2);
        end
        out_ready_v[0] = 1'b1;
        start_v[0]     = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_hs_busy", 32'(busy_v[0]), 32'd0);
            check("post_hs_in_ready", 32'(in_ready_v[0]), 32'd0);
        end

        set_ops3(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        run(0, 16'h0000, 3, 1'b0, -1, -1);
        wait_idle(0);
        set_ops3(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
        run(0, 16'hFFF0, 3, 1'b0, -1, -1);
        wait_idle(0);

        set_ops3(16'd7, 16'd9, 16'd2, 16'd2, 16'd0, 16'd0);
        run(0, 16'd100, 3, 1'b0, -1, 1);
        set_ops3(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
        run(0, 16'd1, 3, 1'b0, -1, -1);
        wait_idle(0);

        op_a[0] = 16'd3; op_b[0] = 16'd3;
        run(1, 16'd7, 1, 1'b0, -1, -1);
        wait_idle(1);

        rnd_rdy = 1'b1;
        for (int k = 0; k < 26; k++) begin
            int d;
            d = (k % 4 == 3) ? 1 : 0;
            for (int i = 0; i < 8; i++) begin
                op_a[i] = 16'($urandom);
                op_b[i] = 16'($urandom);
            end
            run(d, 16'($urandom), (d == 0) ? 3 : 1, 1'b1, -1, -1);
            wait_idle(d);
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #1;
        out_ready_v[0] = 1'b1;
        out_ready_v[1] = 1'b1;
        wait_idle(0);
        wait_idle(1);
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
